// File: rtl/vmerge_issue.sv
// vmerge_issue: walks one vmerge/vmv command into register-file reads and ALU requests; VMERGE_SCALAR_EN adds a replicated-scalar vec1 source.
// Latency: first read the cycle after accept; each ALU request one cycle after its read; done coincides with the last request.
// Backpressure: cmd_ready only in IDLE; stall gaps reads (beats already read still deliver); the ALU side never backpressures.
module vmerge_issue #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int VL_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [VL_WIDTH-1:0]   cmd_vl,
    input  logic [1:0]            cmd_sew,
    input  logic                  cmd_vm,
    input  logic [DATA_WIDTH-1:0] cmd_v0,
    input  logic [ADDR_WIDTH-1:0] cmd_vd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_vs1_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_vs2_addr,
`ifdef VMERGE_SCALAR_EN
    input  logic                  cmd_use_scalar,
    input  logic [63:0]           cmd_scalar,
`endif
    input  logic                  stall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr0,
    output logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    output logic                  alu_valid,
    output logic [ADDR_WIDTH-1:0] alu_addr,
    output logic [MASK_WIDTH-1:0] alu_mask,
    output logic [DATA_WIDTH-1:0] alu_vec0,
    output logic [DATA_WIDTH-1:0] alu_vec1,
    output logic                  done
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int BSH    = $clog2(MASK_WIDTH);
    localparam int BYTE_W = VL_WIDTH + 4;
    localparam int G_W    = CNT_W + BSH;
    localparam int EIDX_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]      beat;
    logic [CNT_W-1:0]      n_beats;
    logic [VL_WIDTH-1:0]   vl_q;
    logic [1:0]            sew_q;
    logic                  vm_q;
    logic [DATA_WIDTH-1:0] v0_q;
    logic [ADDR_WIDTH-1:0] vd_q;
    logic [ADDR_WIDTH-1:0] vs1_q;
    logic [ADDR_WIDTH-1:0] vs2_q;

    logic                  accept;
    logic                  last_beat;
    logic [VL_WIDTH-1:0]   cmd_vl_c;
    logic [BYTE_W-1:0]     cmd_bytes;
    logic [CNT_W-1:0]      cmd_beats;
    logic [MASK_WIDTH-1:0] mask_nxt;
    logic [G_W-1:0]        g;
    logic [G_W-1:0]        e;
    logic [DATA_WIDTH-1:0] vec1_src;

    // Clamp vl to the beat width, then round the byte count up to whole beats.
    always_comb begin
        cmd_vl_c = cmd_vl;
        if (int'(cmd_vl) > DATA_WIDTH)
            cmd_vl_c = VL_WIDTH'(DATA_WIDTH);
        cmd_bytes = BYTE_W'(cmd_vl_c) << cmd_sew;
        cmd_beats = CNT_W'((cmd_bytes + BYTE_W'(MASK_WIDTH - 1)) >> BSH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        rd_en      = 1'b0;
        accept     = 1'b0;
        last_beat  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_beats != '0)
                        next_state = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    rd_en = 1'b1;
                    if (beat == n_beats - CNT_W'(1)) begin
                        last_beat  = 1'b1;
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Byte j of beat b is global byte g; its element is g >> sew.
    always_comb begin
        mask_nxt = '0;
        g        = '0;
        e        = '0;
        for (int j = 0; j < MASK_WIDTH; j++) begin
            g = (G_W'(beat) << BSH) | G_W'(j);
            e = g >> sew_q;
            mask_nxt[j] = (e < G_W'(vl_q)) && (vm_q || v0_q[e[EIDX_W-1:0]]);
        end
    end

`ifdef VMERGE_SCALAR_EN
    logic        use_scalar_q;
    logic [63:0] scalar_q;
    logic [DATA_WIDTH-1:0] scalar_rep;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            use_scalar_q <= 1'b0;
            scalar_q     <= '0;
        end else if (accept) begin
            use_scalar_q <= cmd_use_scalar;
            scalar_q     <= cmd_scalar;
        end
    end

    // Replicate the low SEW bytes of the scalar across the whole beat.
    always_comb begin
        scalar_rep = '0;
        for (int j = 0; j < MASK_WIDTH; j++)
            scalar_rep[8*j +: 8] = scalar_q[8*(j & ((1 << sew_q) - 1)) +: 8];
    end

    assign vec1_src = use_scalar_q ? scalar_rep : rd_data1;
    assign rd_addr1 = (state == RUN && !use_scalar_q) ? vs1_q + ADDR_WIDTH'(beat) : '0;
`else
    assign vec1_src = rd_data1;
    assign rd_addr1 = (state == RUN) ? vs1_q + ADDR_WIDTH'(beat) : '0;
`endif

    assign rd_addr0 = (state == RUN) ? vs2_q + ADDR_WIDTH'(beat) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat    <= '0;
            n_beats <= '0;
            vl_q    <= '0;
            sew_q   <= '0;
            vm_q    <= 1'b0;
            v0_q    <= '0;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
        end else if (accept) begin
            beat    <= '0;
            n_beats <= cmd_beats;
            vl_q    <= cmd_vl_c;
            sew_q   <= cmd_sew;
            vm_q    <= cmd_vm;
            v0_q    <= cmd_v0;
            vd_q    <= cmd_vd_addr;
            vs1_q   <= cmd_vs1_addr;
            vs2_q   <= cmd_vs2_addr;
        end else if (rd_en) begin
            beat    <= beat + CNT_W'(1);
        end
    end

    // Request stage: address and mask registered alongside the read, data arrives next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_valid <= 1'b0;
            alu_addr  <= '0;
            alu_mask  <= '0;
            done      <= 1'b0;
        end else begin
            alu_valid <= rd_en;
            done      <= last_beat || (accept && cmd_beats == '0);
            if (rd_en) begin
                alu_addr <= vd_q + ADDR_WIDTH'(beat);
                alu_mask <= mask_nxt;
            end
        end
    end

    assign alu_vec0 = alu_valid ? rd_data0 : '0;
    assign alu_vec1 = alu_valid ? vec1_src : '0;

endmodule

// File: tb/tb_vmerge_issue.sv
// Directed bench for vmerge_issue: command table with hand-computed masks, plus stall and mid-command reset sequences.
module tb_vmerge_issue;

    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_vl;
    logic [1:0]  cmd_sew;
    logic        cmd_vm;
    logic [63:0] cmd_v0;
    logic [31:0] cmd_vd_addr, cmd_vs1_addr, cmd_vs2_addr;
    logic        stall;
    logic        rd_en;
    logic [31:0] rd_addr0, rd_addr1;
    logic [63:0] rd_data0 = JUNK;
    logic [63:0] rd_data1 = JUNK;
    logic        alu_valid;
    logic [31:0] alu_addr;
    logic [7:0]  alu_mask;
    logic [63:0] alu_vec0, alu_vec1;
    logic        done;
`ifdef VMERGE_SCALAR_EN
    logic        cmd_use_scalar = 1'b0;
    logic [63:0] cmd_scalar = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vmerge_issue dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_vl(cmd_vl), .cmd_sew(cmd_sew), .cmd_vm(cmd_vm), .cmd_v0(cmd_v0),
        .cmd_vd_addr(cmd_vd_addr), .cmd_vs1_addr(cmd_vs1_addr), .cmd_vs2_addr(cmd_vs2_addr),
`ifdef VMERGE_SCALAR_EN
        .cmd_use_scalar(cmd_use_scalar), .cmd_scalar(cmd_scalar),
`endif
        .stall(stall), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_mask(alu_mask),
        .alu_vec0(alu_vec0), .alu_vec1(alu_vec1), .done(done)
    );

    function automatic logic [63:0] f0(input logic [31:0] a);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic logic [63:0] f1(input logic [31:0] a);
        return {~a, a ^ 32'h0000_C3C3};
    endfunction

    // Register-file model: one-cycle read latency, junk when not read.
    always @(posedge clk) begin
        rd_data0 <= rd_en ? f0(rd_addr0) : JUNK;
        rd_data1 <= rd_en ? f1(rd_addr1) : JUNK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  sew;
        logic [6:0]  vl;
        logic        vm;
        logic [63:0] v0;
        logic [31:0] vd;
        logic [31:0] vs1;
        logic [31:0] vs2;
        int          nbeats;
        logic [63:0] masks;   // beat k mask in bits [8k+7:8k]
        int          stl;     // stall cycles right after beat 0's read
    } vec_t;

    vec_t tv[10];

    task automatic drive_cmd(input vec_t v);
        cmd_sew      = v.sew;
        cmd_vl       = v.vl;
        cmd_vm       = v.vm;
        cmd_v0       = v.v0;
        cmd_vd_addr  = v.vd;
        cmd_vs1_addr = v.vs1;
        cmd_vs2_addr = v.vs2;
        cmd_valid    = 1'b1;
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int beats = 0, rds = 0, dones = 0, done_cyc = -1, busy = 0, leak = 0;
        int exp_last, exp_cyc, win;
        logic [31:0] a0, a1, ad;
        exp_last = (v.nbeats == 0) ? 1 : v.nbeats + 1 + ((v.nbeats > 1) ? v.stl : 0);
        win = exp_last + 6;
        @(negedge clk);
        stall = 1'b0;
        drive_cmd(v);
        #1 chk({tag, " ready_before"}, cmd_ready, 1);
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            stall = (c >= 2 && c < 2 + v.stl);
            #1;
            if (rd_en) rds++;
            if (!cmd_ready) busy++;
            if (done) begin dones++; done_cyc = c; end
            if (!alu_valid && (alu_vec0 != '0 || alu_vec1 != '0)) leak++;
            if (alu_valid) begin
                if (beats < 8) begin
                    ad = v.vd + 32'(beats);
                    a0 = v.vs2 + 32'(beats);
                    a1 = v.vs1 + 32'(beats);
                    exp_cyc = (beats == 0) ? 2 : beats + 2 + v.stl;
                    chk($sformatf("%s b%0d mask", tag, beats), alu_mask, v.masks[8*beats +: 8]);
                    chk($sformatf("%s b%0d addr", tag, beats), alu_addr, ad);
                    chk($sformatf("%s b%0d vec0", tag, beats), alu_vec0, f0(a0));
                    chk($sformatf("%s b%0d vec1", tag, beats), alu_vec1, f1(a1));
                    chk($sformatf("%s b%0d cycle", tag, beats), c, exp_cyc);
                end
                beats++;
            end
        end
        stall = 1'b0;
        chk({tag, " beats"}, beats, v.nbeats);
        chk({tag, " reads"}, rds, v.nbeats);
        chk({tag, " done_count"}, dones, 1);
        chk({tag, " done_cycle"}, done_cyc, exp_last);
        chk({tag, " busy_cycles"}, busy, (v.nbeats == 0) ? 0 : exp_last);
        chk({tag, " vec_leak"}, leak, 0);
    endtask

    initial begin
        int extra;
        tv[0] = '{2'd0, 7'd10,  1'b0, 64'h155, 32'h40, 32'h200, 32'h300, 2, 64'h0155, 0};
        tv[1] = '{2'd1, 7'd5,   1'b0, 64'h1A,  32'h80, 32'h1000, 32'h2000, 2, 64'h03CC, 0};
        tv[2] = '{2'd3, 7'd3,   1'b1, 64'h0,   32'h100, 32'h10, 32'h20, 3, 64'hFF_FFFF, 0};
        tv[3] = '{2'd0, 7'd10,  1'b0, 64'h155, 32'h40, 32'h200, 32'h300, 2, 64'h0155, 3};
        tv[4] = '{2'd0, 7'd0,   1'b1, 64'hFF,  32'h50, 32'h60, 32'h70, 0, 64'h0, 0};
        tv[5] = '{2'd3, 7'd2,   1'b0, 64'h2,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 64'hFF00, 0};
        tv[6] = '{2'd2, 7'd3,   1'b0, 64'h6,   32'h20, 32'h30, 32'h40, 2, 64'h0FF0, 0};
        tv[7] = '{2'd0, 7'd100, 1'b1, 64'h0,   32'h0, 32'h400, 32'h500, 8, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        tv[8] = '{2'd0, 7'd64,  1'b0, 64'h8000_0000_0000_0001, 32'h600, 32'h700, 32'h800, 8, 64'h8000_0000_0000_0001, 0};
        tv[9] = '{2'd0, 7'd3,   1'b1, 64'h0,   32'h90, 32'hA0, 32'hB0, 1, 64'h07, 0};

        rst = 1'b0;
        cmd_valid = 1'b0; cmd_vl = '0; cmd_sew = '0; cmd_vm = 1'b0; cmd_v0 = '0;
        cmd_vd_addr = '0; cmd_vs1_addr = '0; cmd_vs2_addr = '0; stall = 1'b0;
        #2;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset rd_en", rd_en, 0);
        chk("reset alu_valid", alu_valid, 0);
        chk("reset done", done, 0);
        chk("reset rd_addr0", rd_addr0, 0);
        chk("reset rd_addr1", rd_addr1, 0);
        chk("reset alu_addr", alu_addr, 0);
        chk("reset alu_mask", alu_mask, 0);
        chk("reset alu_vec0", alu_vec0, 0);
        chk("reset alu_vec1", alu_vec1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            run_cmd(tv[i], $sformatf("vec%0d", i));

        // Reset while beat 1 of a 3-beat command is being read.
        @(negedge clk);
        drive_cmd(tv[2]);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1 chk("rstmid pre alu_valid", alu_valid, 1);
        rst = 1'b0;
        #1;
        chk("rstmid cmd_ready", cmd_ready, 1);
        chk("rstmid rd_en", rd_en, 0);
        chk("rstmid alu_valid", alu_valid, 0);
        chk("rstmid done", done, 0);
        chk("rstmid rd_addr0", rd_addr0, 0);
        chk("rstmid alu_addr", alu_addr, 0);
        chk("rstmid alu_mask", alu_mask, 0);
        chk("rstmid alu_vec0", alu_vec0, 0);
        chk("rstmid alu_vec1", alu_vec1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (rd_en || alu_valid || done || !cmd_ready) extra++;
        end
        chk("rstmid quiet_after", extra, 0);
        run_cmd(tv[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
